// File: rtl/relay_credit_pipe.sv
// Register chain with a valid bit; used on both the data and credit directions.
// WIDTH=0 still keeps a one-bit pad lane so the data ports never collapse to zero width.
module relay_credit_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LEVEL = 2,
    localparam int unsigned DW   = (WIDTH > 0) ? WIDTH : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic [LEVEL-1:0] valid_q;
    logic [DW-1:0]    data_q [LEVEL];

    // Shift one stage per clock; reset flushes everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(LEVEL); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_data;
            for (int i = 1; i < int'(LEVEL); i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LEVEL-1];
    assign out_data  = data_q[LEVEL-1];

endmodule

// File: rtl/relay_credit_tx.sv
// Transmit end of a credit-based stream link: pipelined data out, pipelined
// credit return in, and a credit window that gates the producer.
module relay_credit_tx #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CREDITS    = 8,
    parameter int unsigned LEVEL      = 2,
    localparam int unsigned CNT_WIDTH = $clog2(CREDITS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  link_valid,
    output logic [DATA_WIDTH-1:0] link_data,
    input  logic                  link_credit,
    output logic [CNT_WIDTH-1:0]  credit_count,
    output logic                  credit_err
);

    localparam int unsigned SUM_W = CNT_WIDTH + 1;

    logic                 accept;
    logic                 crd_valid;
    logic [0:0]           crd_mark;
    logic                 ret;
    logic [SUM_W-1:0]     sum;
    logic                 over;
    logic [CNT_WIDTH-1:0] credit_next;

    assign accept = if_write & if_write_ce & if_full_n;

    relay_credit_pipe #(
        .WIDTH (DATA_WIDTH),
        .LEVEL (LEVEL)
    ) u_data_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (accept),
        .in_data   (if_din),
        .out_valid (link_valid),
        .out_data  (link_data)
    );

    // Credit direction is valid-only; the pad lane mirrors the pulse.
    relay_credit_pipe #(
        .WIDTH (0),
        .LEVEL (LEVEL)
    ) u_credit_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (link_credit),
        .in_data   (link_credit),
        .out_valid (crd_valid),
        .out_data  (crd_mark)
    );

    assign ret = crd_valid & crd_mark[0];

    // Next credit value with saturation at the receiver depth.
    always_comb begin
        sum         = '0;
        over        = 1'b0;
        credit_next = credit_count;
        sum         = SUM_W'(credit_count) - SUM_W'(accept) + SUM_W'(ret);
        over        = (sum > SUM_W'(CREDITS));
        credit_next = over ? CNT_WIDTH'(CREDITS) : sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credit_count <= CNT_WIDTH'(CREDITS);
            credit_err   <= 1'b0;
            if_full_n    <= 1'b0;
        end else begin
            credit_count <= credit_next;
            if_full_n    <= (credit_next != '0);
            if (over) begin
                credit_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_relay_credit_tx.sv
// Directed bench for relay_credit_tx with a scoreboard on the link side.
module tb_relay_credit_tx;

    localparam int unsigned DW  = 32;
    localparam int unsigned CR  = 8;
    localparam int unsigned LV  = 2;
    localparam int unsigned CW  = $clog2(CR + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          if_full_n;
    logic          if_write_ce;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          link_valid;
    logic [DW-1:0] link_data;
    logic          link_credit;
    logic [CW-1:0] credit_count;
    logic          credit_err;

    relay_credit_tx #(
        .DATA_WIDTH (DW),
        .CREDITS    (CR),
        .LEVEL      (LV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_full_n    (if_full_n),
        .if_write_ce  (if_write_ce),
        .if_write     (if_write),
        .if_din       (if_din),
        .link_valid   (link_valid),
        .link_data    (link_data),
        .link_credit  (link_credit),
        .credit_count (credit_count),
        .credit_err   (credit_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            at;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic expect_word(input logic [DW-1:0] d, input int at);
        exp_t e;
        e.data = d;
        e.at   = at;
        q.push_back(e);
    endtask

    // Monitor: every link word must match the next expected word and cycle.
    always @(negedge clk) begin
        if (mon_en && link_valid) begin
            exp_t e;
            if (q.size() == 0) begin
                check("unexpected_link_valid", 32'(link_data), 32'hdead_beef);
            end else begin
                e = q.pop_front();
                check("link_data", 32'(link_data), 32'(e.data));
                check("link_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    initial begin
        int t;
        reset       = 1'b1;
        if_write_ce = 1'b1;
        if_write    = 1'b0;
        if_din      = '0;
        link_credit = 1'b0;

        // Reset then idle
        repeat (3) next_cycle();
        sample();
        check("rst_full_n", 32'(if_full_n), 32'd0);
        mon_en = 1'b1;
        next_cycle();
        reset = 1'b0;
        sample();
        check("rst_last_full_n", 32'(if_full_n), 32'd0);
        next_cycle();
        sample();
        check("post_rst_full_n", 32'(if_full_n), 32'd1);
        check("post_rst_count", 32'(credit_count), 32'd8);
        check("post_rst_valid", 32'(link_valid), 32'd0);

        // Burst of writes with no credits returned
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            if_write = 1'b1;
            if_din   = DW'(32'h10 + i);
            sample();
            check("burst_full_n", 32'(if_full_n), 32'd1);
            expect_word(DW'(32'h10 + i), cyc + 2);
        end
        next_cycle();
        if_din = DW'(32'h18);
        sample();
        check("burst_stall_full_n", 32'(if_full_n), 32'd0);
        check("burst_stall_count", 32'(credit_count), 32'd0);
        repeat (4) begin
            next_cycle();
            sample();
            check("held_full_n", 32'(if_full_n), 32'd0);
        end

        // Single credit return releases the held word
        next_cycle();
        link_credit = 1'b1;
        t = cyc;
        next_cycle();
        link_credit = 1'b0;
        sample();
        check("crd_t1_count", 32'(credit_count), 32'd0);
        next_cycle();
        sample();
        check("crd_t2_full_n", 32'(if_full_n), 32'd0);
        next_cycle();
        sample();
        check("crd_t3_cycle", 32'(cyc), 32'(t + 3));
        check("crd_t3_count", 32'(credit_count), 32'd1);
        check("crd_t3_full_n", 32'(if_full_n), 32'd1);
        expect_word(DW'(32'h18), cyc + 2);
        next_cycle();
        if_write = 1'b0;
        sample();
        check("crd_t4_full_n", 32'(if_full_n), 32'd0);
        check("crd_t4_count", 32'(credit_count), 32'd0);

        // Accept coinciding with a returned credit at count 1
        next_cycle();
        link_credit = 1'b1;
        next_cycle();
        link_credit = 1'b1;
        next_cycle();
        link_credit = 1'b0;
        sample();
        check("sim_pre_count", 32'(credit_count), 32'd0);
        next_cycle();
        if_write = 1'b1;
        if_din   = DW'(32'h20);
        sample();
        check("sim_count", 32'(credit_count), 32'd1);
        check("sim_full_n", 32'(if_full_n), 32'd1);
        expect_word(DW'(32'h20), cyc + 2);
        next_cycle();
        if_write_ce = 1'b0;
        if_din      = DW'(32'h21);
        sample();
        check("sim_after_count", 32'(credit_count), 32'd1);
        check("sim_after_full_n", 32'(if_full_n), 32'd1);
        next_cycle();
        if_write    = 1'b0;
        if_write_ce = 1'b1;
        sample();
        check("ce_off_count", 32'(credit_count), 32'd1);
        repeat (3) next_cycle();

        // Refill to the maximum, then overflow
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            link_credit = 1'b1;
        end
        next_cycle();
        link_credit = 1'b0;
        repeat (3) next_cycle();
        sample();
        check("refill_count", 32'(credit_count), 32'd8);
        check("refill_err", 32'(credit_err), 32'd0);
        next_cycle();
        link_credit = 1'b1;
        next_cycle();
        link_credit = 1'b0;
        repeat (2) next_cycle();
        sample();
        check("ovf_count", 32'(credit_count), 32'd8);
        check("ovf_err", 32'(credit_err), 32'd1);
        repeat (5) next_cycle();
        sample();
        check("ovf_sticky", 32'(credit_err), 32'd1);

        // Reset with two words and two credits in flight
        next_cycle();
        if_write    = 1'b1;
        if_din      = DW'(32'h30);
        link_credit = 1'b1;
        next_cycle();
        if_din = DW'(32'h31);
        reset  = 1'b1;
        next_cycle();
        reset       = 1'b0;
        if_write    = 1'b0;
        link_credit = 1'b0;
        sample();
        check("mid_rst_count", 32'(credit_count), 32'd8);
        check("mid_rst_err", 32'(credit_err), 32'd0);
        check("mid_rst_valid", 32'(link_valid), 32'd0);
        next_cycle();
        sample();
        check("mid_rst_full_n", 32'(if_full_n), 32'd1);
        check("mid_rst_count2", 32'(credit_count), 32'd8);
        repeat (6) next_cycle();
        sample();

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
